// File: rtl/bram_port_arbiter_if.sv
// Bundle of requester-side and BRAM-side signals around the shared BRAM port arbiter.
// slave is the arbiter's view; master is the surrounding requesters plus BRAM.
interface bram_port_arbiter_if #(
  parameter int unsigned BRAM_DEPTH = 12,
  parameter int unsigned BRAM_WIDTH = 1152
);

  logic                  req0;
  logic                  wen0;
  logic [BRAM_DEPTH-1:0] addr0;
  logic [BRAM_WIDTH-1:0] din0;
  logic                  gnt0;
  logic                  rvalid0;

  logic                  req1;
  logic                  wen1;
  logic [BRAM_DEPTH-1:0] addr1;
  logic [BRAM_WIDTH-1:0] din1;
  logic                  gnt1;
  logic                  rvalid1;

  logic [BRAM_WIDTH-1:0] rdata;

  logic                  bram_en;
  logic                  bram_wen;
  logic [BRAM_DEPTH-1:0] bram_addr;
  logic [BRAM_WIDTH-1:0] bram_in;
  logic [BRAM_WIDTH-1:0] bram_out;

  modport slave (
    input  req0, wen0, addr0, din0,
    input  req1, wen1, addr1, din1,
    input  bram_out,
    output gnt0, rvalid0, gnt1, rvalid1, rdata,
    output bram_en, bram_wen, bram_addr, bram_in
  );

  modport master (
    output req0, wen0, addr0, din0,
    output req1, wen1, addr1, din1,
    output bram_out,
    input  gnt0, rvalid0, gnt1, rvalid1, rdata,
    input  bram_en, bram_wen, bram_addr, bram_in
  );

endinterface

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one BRAM port between the stream-write path (0)
// and the read-back path (1), with bounded bursts and tagged fixed-latency reads.
module bram_port_arbiter #(
  parameter int unsigned BRAM_DEPTH = 12,
  parameter int unsigned BRAM_WIDTH = 1152,
  parameter int unsigned MAX_BURST  = 8,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic               clk,
  input  logic               rst,
  bram_port_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  // One-hot owner encoding: each grant is a flop bit of the state register.
  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN0     = 2'b01,
    OWN1     = 2'b10
  } owner_e;

  typedef struct packed {
    logic valid;
    logic tag;
  } rd_ent_t;

  owner_e          owner;
  logic [CNT_W-1:0] beat_cnt;
  logic            last_served;
  rd_ent_t         rd_pipe [RD_LATENCY];

  logic                  acc0_c;
  logic                  acc1_c;
  logic                  burst_end_c;
  logic                  bram_en_c;
  logic                  bram_wen_c;
  logic [BRAM_DEPTH-1:0] bram_addr_c;
  logic [BRAM_WIDTH-1:0] bram_in_c;

  assign acc0_c      = owner[0] & bus.req0 & ~rst;
  assign acc1_c      = owner[1] & bus.req1 & ~rst;
  assign burst_end_c = (beat_cnt == LAST_BEAT);

  // Steer the accepted beat onto the BRAM pins; idle pins are held at zero.
  always_comb begin
    bram_en_c   = 1'b0;
    bram_wen_c  = 1'b0;
    bram_addr_c = '0;
    bram_in_c   = '0;
    if (acc0_c) begin
      bram_en_c   = 1'b1;
      bram_wen_c  = bus.wen0;
      bram_addr_c = bus.addr0;
      bram_in_c   = bus.din0;
    end else if (acc1_c) begin
      bram_en_c   = 1'b1;
      bram_wen_c  = bus.wen1;
      bram_addr_c = bus.addr1;
      bram_in_c   = bus.din1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner       <= OWN_NONE;
      beat_cnt    <= '0;
      last_served <= 1'b1;
      for (int i = 0; i < int'(RD_LATENCY); i++) begin
        rd_pipe[i] <= '0;
      end
    end else begin
      rd_pipe[0] <= rd_ent_t'{valid: bram_en_c & ~bram_wen_c, tag: acc1_c};
      for (int i = 1; i < int'(RD_LATENCY); i++) begin
        rd_pipe[i] <= rd_pipe[i-1];
      end

      unique case (owner)
        OWN_NONE: begin
          if (bus.req0 && (!bus.req1 || last_served)) begin
            owner <= OWN0;
          end else if (bus.req1) begin
            owner <= OWN1;
          end
        end
        OWN0: begin
          if (!bus.req0) begin
            owner       <= bus.req1 ? OWN1 : OWN_NONE;
            beat_cnt    <= '0;
            last_served <= 1'b0;
          end else if (burst_end_c) begin
            // Burst exhausted: hand over only if the other side is waiting.
            beat_cnt <= '0;
            if (bus.req1) begin
              owner       <= OWN1;
              last_served <= 1'b0;
            end
          end else begin
            beat_cnt <= beat_cnt + CNT_W'(1);
          end
        end
        OWN1: begin
          if (!bus.req1) begin
            owner       <= bus.req0 ? OWN0 : OWN_NONE;
            beat_cnt    <= '0;
            last_served <= 1'b1;
          end else if (burst_end_c) begin
            beat_cnt <= '0;
            if (bus.req0) begin
              owner       <= OWN0;
              last_served <= 1'b1;
            end
          end else begin
            beat_cnt <= beat_cnt + CNT_W'(1);
          end
        end
        default: begin
          owner <= OWN_NONE;
        end
      endcase
    end
  end

  assign bus.gnt0      = owner[0];
  assign bus.gnt1      = owner[1];
  assign bus.rvalid0   = rd_pipe[RD_LATENCY-1].valid & ~rd_pipe[RD_LATENCY-1].tag;
  assign bus.rvalid1   = rd_pipe[RD_LATENCY-1].valid &  rd_pipe[RD_LATENCY-1].tag;
  assign bus.rdata     = bus.bram_out;
  assign bus.bram_en   = bram_en_c;
  assign bus.bram_wen  = bram_wen_c;
  assign bus.bram_addr = bram_addr_c;
  assign bus.bram_in   = bram_in_c;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Scoreboard bench for bram_port_arbiter: directed per-cycle rows push expected
// grants, BRAM beats and tagged read returns; a negedge monitor pops and compares.
module tb_bram_port_arbiter;

  localparam int unsigned D  = 12;
  localparam int unsigned W  = 64;
  localparam int unsigned MB = 4;
  localparam int unsigned RL = 2;

  // Expected {gnt0,gnt1} per cycle for the continuous two-requester run.
  localparam logic [1:0] G2 [15] = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b10,
                                     2'b01, 2'b01, 2'b01, 2'b01,
                                     2'b10, 2'b10, 2'b10, 2'b10,
                                     2'b01, 2'b01};

  typedef struct {
    int   cyc;
    logic g0;
    logic g1;
  } gexp_t;

  typedef struct {
    int           cyc;
    logic         wen;
    logic [D-1:0] addr;
    logic [W-1:0] din;
  } bexp_t;

  typedef struct {
    int           cyc;
    logic         tag;
    logic [W-1:0] data;
  } rexp_t;

  logic clk = 1'b0;
  logic rst;

  gexp_t gq [$];
  bexp_t bq [$];
  rexp_t rq [$];
  gexp_t mg;
  bexp_t mb;
  rexp_t me;

  int cyc;
  bit armed;
  int n_vec;
  int n_err;

  logic [W-1:0] rd_p0;
  logic [W-1:0] rd_p1;

  always #5 clk = ~clk;

  bram_port_arbiter_if #(.BRAM_DEPTH(D), .BRAM_WIDTH(W)) bus ();

  bram_port_arbiter #(
    .BRAM_DEPTH(D),
    .BRAM_WIDTH(W),
    .MAX_BURST (MB),
    .RD_LATENCY(RL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // BRAM model: read data equals the address, RL cycles after issue.
  always @(posedge clk) begin
    rd_p0 <= (bus.bram_en && !bus.bram_wen) ? W'(bus.bram_addr) : '0;
    rd_p1 <= rd_p0;
  end
  assign bus.bram_out = rd_p1;

  function automatic logic [W-1:0] din_of(input bit k, input logic [D-1:0] a);
    return W'({k ? 8'hE1 : 8'hD0, 4'h0, a});
  endfunction

  task automatic check(input string name, input bit ok,
                       input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // One stimulus cycle plus its hand-computed expected grant state.
  task automatic row(input bit r,
                     input bit q0, input bit w0, input logic [D-1:0] a0,
                     input bit q1, input bit w1, input logic [D-1:0] a1,
                     input bit eg0, input bit eg1);
    @(posedge clk);
    #1;
    cyc++;
    rst       = r;
    bus.req0  = q0;
    bus.wen0  = w0;
    bus.addr0 = a0;
    bus.din0  = din_of(1'b0, a0);
    bus.req1  = q1;
    bus.wen1  = w1;
    bus.addr1 = a1;
    bus.din1  = din_of(1'b1, a1);
    gq.push_back(gexp_t'{cyc, eg0, eg1});
    if (r) begin
      while (rq.size() > 0 && rq[$].cyc > cyc) void'(rq.pop_back());
    end else begin
      if (eg0 && q0) begin
        bq.push_back(bexp_t'{cyc, w0, a0, din_of(1'b0, a0)});
        if (!w0) rq.push_back(rexp_t'{cyc + int'(RL), 1'b0, W'(a0)});
      end
      if (eg1 && q1) begin
        bq.push_back(bexp_t'{cyc, w1, a1, din_of(1'b1, a1)});
        if (!w1) rq.push_back(rexp_t'{cyc + int'(RL), 1'b1, W'(a1)});
      end
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      if (gq.size() == 0) begin
        check("gnt_queue_empty", 1'b0, W'({bus.gnt0, bus.gnt1}), '0);
      end else begin
        mg = gq.pop_front();
        check("gnt", mg.cyc == cyc && bus.gnt0 == mg.g0 && bus.gnt1 == mg.g1,
              W'({bus.gnt0, bus.gnt1}), W'({mg.g0, mg.g1}));
      end

      if (bus.bram_en) begin
        if (bq.size() == 0) begin
          check("bram_unexpected", 1'b0, W'(bus.bram_addr), '0);
        end else begin
          mb = bq.pop_front();
          check("bram_cycle", mb.cyc == cyc, W'(cyc), W'(mb.cyc));
          check("bram_wen", bus.bram_wen == mb.wen, W'(bus.bram_wen), W'(mb.wen));
          check("bram_addr", bus.bram_addr == mb.addr, W'(bus.bram_addr), W'(mb.addr));
          check("bram_in", bus.bram_in == mb.din, bus.bram_in, mb.din);
        end
      end else begin
        check("bram_idle", !bus.bram_wen && bus.bram_addr == '0 && bus.bram_in == '0,
              W'(bus.bram_addr), '0);
        if (bq.size() > 0 && bq[0].cyc <= cyc) begin
          mb = bq.pop_front();
          check("bram_missing", 1'b0, '0, W'(mb.addr));
        end
      end

      if (bus.rvalid0 && bus.rvalid1) begin
        check("rvalid_both", 1'b0, W'(2'b11), '0);
      end else if (bus.rvalid0 || bus.rvalid1) begin
        if (rq.size() == 0) begin
          check("rvalid_unexpected", 1'b0, bus.rdata, '0);
        end else begin
          me = rq.pop_front();
          check("rvalid_cycle", me.cyc == cyc, W'(cyc), W'(me.cyc));
          check("rvalid_tag", bus.rvalid1 == me.tag, W'(bus.rvalid1), W'(me.tag));
          check("rdata", bus.rdata == me.data, bus.rdata, me.data);
        end
      end else if (rq.size() > 0 && rq[0].cyc <= cyc) begin
        me = rq.pop_front();
        check("rvalid_missing", 1'b0, '0, me.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int n0;
    int n1;
    bit q0;
    bit q1;
    rst       = 1'b1;
    bus.req0  = 1'b0;
    bus.wen0  = 1'b0;
    bus.addr0 = '0;
    bus.din0  = '0;
    bus.req1  = 1'b0;
    bus.wen1  = 1'b0;
    bus.addr1 = '0;
    bus.din1  = '0;
    cyc       = 0;
    n_vec     = 0;
    n_err     = 0;
    armed     = 1'b1;

    // Reset state
    row(1, 0,0,12'h000, 0,0,12'h000, 0,0);

    // Requester 0 alone: 5 write beats, burst wrap without a bubble
    row(0, 1,1,12'h000, 0,0,12'h000, 0,0);
    for (int i = 0; i < 5; i++) row(0, 1,1,D'(i), 0,0,12'h000, 1,0);
    row(0, 0,0,12'h000, 0,0,12'h000, 1,0);
    row(0, 0,0,12'h000, 0,0,12'h000, 0,0);

    // Both requesting from reset: alternating 4-beat groups
    row(1, 0,0,12'h000, 0,0,12'h000, 0,0);
    n0 = 0;
    n1 = 0;
    for (int i = 0; i < 15; i++) begin
      q0 = (i < 13);
      q1 = (i < 14);
      row(0, q0,1,D'(32'h100 + n0), q1,1,D'(32'h200 + n1), G2[i][1], G2[i][0]);
      if (q0 && G2[i][1]) n0++;
      if (q1 && G2[i][0]) n1++;
    end
    row(0, 0,0,12'h000, 0,0,12'h000, 0,0);

    // Requester 1 back-to-back reads of 7 and 9
    row(0, 0,0,12'h000, 1,0,12'h007, 0,0);
    row(0, 0,0,12'h000, 1,0,12'h007, 0,1);
    row(0, 0,0,12'h000, 1,0,12'h009, 0,1);
    row(0, 0,0,12'h000, 0,0,12'h000, 0,1);
    row(0, 0,0,12'h000, 0,0,12'h000, 0,0);
    row(0, 0,0,12'h000, 0,0,12'h000, 0,0);

    // Read on requester 0's last burst beat, then requester 1 read after the switch
    row(0, 1,1,12'h020, 1,0,12'h030, 0,0);
    row(0, 1,1,12'h020, 1,0,12'h030, 1,0);
    row(0, 1,1,12'h021, 1,0,12'h030, 1,0);
    row(0, 1,1,12'h022, 1,0,12'h030, 1,0);
    row(0, 1,0,12'h023, 1,0,12'h030, 1,0);
    row(0, 0,0,12'h000, 1,0,12'h030, 0,1);
    row(0, 0,0,12'h000, 0,0,12'h000, 0,1);
    row(0, 0,0,12'h000, 0,0,12'h000, 0,0);
    row(0, 0,0,12'h000, 0,0,12'h000, 0,0);

    // Early release by requester 0; requester 1 then gets a full burst
    row(0, 1,1,12'h040, 1,1,12'h050, 0,0);
    row(0, 1,1,12'h040, 1,1,12'h050, 1,0);
    row(0, 1,1,12'h041, 1,1,12'h050, 1,0);
    row(0, 0,0,12'h000, 1,1,12'h050, 1,0);
    row(0, 1,1,12'h060, 1,1,12'h050, 0,1);
    row(0, 1,1,12'h060, 1,1,12'h051, 0,1);
    row(0, 1,1,12'h060, 1,1,12'h052, 0,1);
    row(0, 1,1,12'h060, 1,1,12'h053, 0,1);
    row(0, 1,1,12'h060, 0,0,12'h000, 1,0);
    row(0, 0,0,12'h000, 0,0,12'h000, 1,0);
    row(0, 0,0,12'h000, 0,0,12'h000, 0,0);

    // Reset with a read in flight while requester 1 owns the port
    row(0, 0,0,12'h000, 1,0,12'h070, 0,0);
    row(0, 0,0,12'h000, 1,0,12'h070, 0,1);
    row(1, 0,0,12'h000, 0,0,12'h000, 0,1);
    row(0, 1,1,12'h080, 1,1,12'h090, 0,0);
    row(0, 1,1,12'h080, 1,1,12'h090, 1,0);
    row(0, 0,0,12'h000, 0,0,12'h000, 1,0);
    row(0, 0,0,12'h000, 0,0,12'h000, 0,0);
    row(0, 0,0,12'h000, 0,0,12'h000, 0,0);
    row(0, 0,0,12'h000, 0,0,12'h000, 0,0);

    @(negedge clk);
    #1;
    check("drain_bram", bq.size() == 0, W'(bq.size()), '0);
    check("drain_read", rq.size() == 0, W'(rq.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
